// File: rtl/pio_xfer_pkg.sv
// Shared types and sig codes for the PIO block transfer controller.
package pio_xfer_pkg;

  localparam logic [1:0] SIG_IDLE  = 2'b00;
  localparam logic [1:0] SIG_WR    = 2'b01;
  localparam logic [1:0] SIG_RD    = 2'b10;
  localparam logic [1:0] SIG_ABORT = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_ACK   = 3'd1,
    ENG_REQ  = 3'd2,
    ENG_WAIT = 3'd3,
    TX_IDLE  = 3'd4,
    TX_ACK   = 3'd5,
    ABORT    = 3'd6
  } xfer_state_e;

  typedef enum logic [2:0] {
    SR_HOLD      = 3'd0,
    SR_CLEAR     = 3'd1,
    SR_LOAD      = 3'd2,
    SR_SHIFT_IN  = 3'd3,
    SR_SHIFT_OUT = 3'd4
  } shreg_op_e;

endpackage

// File: rtl/pio_xfer_if.sv
// PIO handshake and engine block/result bus; slave = controller side.
interface pio_xfer_if #(
  parameter int unsigned NBYTES = 16
);
  logic [7:0]          hw_port_i;
  logic [1:0]          hw_sig_i;
  logic [7:0]          sw_port_o;
  logic [1:0]          sw_sig_o;
  logic [NBYTES*8-1:0] blk_o;
  logic                blk_valid_o;
  logic                blk_ready_i;
  logic [NBYTES*8-1:0] res_i;
  logic                res_valid_i;
  logic                res_ready_o;

  modport slave (
    input  hw_port_i, hw_sig_i, blk_ready_i, res_i, res_valid_i,
    output sw_port_o, sw_sig_o, blk_o, blk_valid_o, res_ready_o
  );

  modport master (
    output hw_port_i, hw_sig_i, blk_ready_i, res_i, res_valid_i,
    input  sw_port_o, sw_sig_o, blk_o, blk_valid_o, res_ready_o
  );
endinterface

// File: rtl/pio_xfer_shreg.sv
// NBYTES-byte block register: clear, parallel load, shift byte in at the
// bottom, shift out from the top (zero fill).
module pio_xfer_shreg
  import pio_xfer_pkg::*;
#(
  parameter int unsigned NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  shreg_op_e           op,
  input  logic [7:0]          din,
  input  logic [NBYTES*8-1:0] load_blk,
  output logic [NBYTES*8-1:0] blk,
  output logic [7:0]          top_c
);
  localparam int unsigned BLK_W = NBYTES * 8;

  // Block register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk <= '0;
    end else begin
      case (op)
        SR_CLEAR:     blk <= '0;
        SR_LOAD:      blk <= load_blk;
        SR_SHIFT_IN:  blk <= {blk[BLK_W-9:0], din};
        SR_SHIFT_OUT: blk <= {blk[BLK_W-9:0], 8'h00};
        default:      blk <= blk;
      endcase
    end
  end

  assign top_c = blk[BLK_W-1 -: 8];
endmodule

// File: rtl/pio_xfer_ctrl.sv
// PIO-to-engine block transfer controller: collects NBYTES bytes over a
// level handshake, hands the block to the engine, returns the result bytewise.
// Optional PIO_XFER_STATUS_EN adds blk_cnt_o, a count of engine handshakes.
module pio_xfer_ctrl
  import pio_xfer_pkg::*;
#(
  parameter int unsigned NBYTES = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  pio_xfer_if.slave        bus
`ifdef PIO_XFER_STATUS_EN
  ,
  output logic [15:0]      blk_cnt_o
`endif
);
  localparam int unsigned BLK_W = NBYTES * 8;
  localparam int unsigned CNT_W = $clog2(NBYTES);

  xfer_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hw_port_q;
  logic [1:0]       hw_sig_q;
  logic [1:0]       sw_sig_d;
  logic [7:0]       sw_port_d;
  shreg_op_e        sr_op;
  logic [BLK_W-1:0] blk_q;
  logic [7:0]       top_c;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(NBYTES - 1));

  pio_xfer_shreg #(.NBYTES(NBYTES)) u_shreg (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .op       (sr_op),
    .din      (hw_port_q),
    .load_blk (bus.res_i),
    .blk      (blk_q),
    .top_c    (top_c)
  );

  assign bus.blk_o = blk_q;

  // Input capture stage; all decisions use these registered values.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hw_port_q <= '0;
      hw_sig_q  <= SIG_IDLE;
    end else begin
      hw_port_q <= bus.hw_port_i;
      hw_sig_q  <= bus.hw_sig_i;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q         <= RX_IDLE;
      cnt_q           <= '0;
      bus.sw_sig_o    <= SIG_IDLE;
      bus.sw_port_o   <= '0;
      bus.blk_valid_o <= 1'b0;
      bus.res_ready_o <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus.sw_sig_o    <= sw_sig_d;
      bus.sw_port_o   <= sw_port_d;
      bus.blk_valid_o <= (state_d == ENG_REQ);
      bus.res_ready_o <= (state_d == ENG_WAIT);
    end
  end

  // Next-state and next-output decode; ABORT code overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sw_sig_d  = bus.sw_sig_o;
    sw_port_d = bus.sw_port_o;
    sr_op     = SR_HOLD;
    if (hw_sig_q == SIG_ABORT) begin
      state_d  = ABORT;
      sw_sig_d = SIG_ABORT;
      cnt_d    = '0;
      sr_op    = SR_CLEAR;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (hw_sig_q == SIG_WR) begin
            sr_op    = SR_SHIFT_IN;
            sw_sig_d = SIG_WR;
            state_d  = RX_ACK;
          end
        end
        RX_ACK: begin
          if (hw_sig_q == SIG_IDLE) begin
            sw_sig_d = SIG_IDLE;
            if (last_c) begin
              cnt_d   = '0;
              state_d = ENG_REQ;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = RX_IDLE;
            end
          end
        end
        ENG_REQ: begin
          if (bus.blk_ready_i) state_d = ENG_WAIT;
        end
        ENG_WAIT: begin
          if (bus.res_valid_i) begin
            sr_op   = SR_LOAD;
            state_d = TX_IDLE;
          end
        end
        TX_IDLE: begin
          if (hw_sig_q == SIG_RD) begin
            sw_port_d = top_c;
            sw_sig_d  = SIG_RD;
            state_d   = TX_ACK;
          end
        end
        TX_ACK: begin
          if (hw_sig_q == SIG_IDLE) begin
            sw_sig_d = SIG_IDLE;
            sr_op    = SR_SHIFT_OUT;
            if (last_c) begin
              cnt_d   = '0;
              state_d = RX_IDLE;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = TX_IDLE;
            end
          end
        end
        ABORT: begin
          if (hw_sig_q == SIG_IDLE) begin
            sw_sig_d = SIG_IDLE;
            state_d  = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

`ifdef PIO_XFER_STATUS_EN
  logic [15:0] blk_cnt_q;
  logic        blk_xfer_c;

  assign blk_xfer_c = (state_q == ENG_REQ) && bus.blk_ready_i && (hw_sig_q != SIG_ABORT);

  // Completed engine handshakes; wraps, cleared by reset only.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)     blk_cnt_q <= '0;
    else if (blk_xfer_c) blk_cnt_q <= blk_cnt_q + 16'd1;
  end

  assign blk_cnt_o = blk_cnt_q;
`endif
endmodule

// File: doc/pio_xfer_ctrl.md
PIO_XFER_CTRL -- requirements
Module: pio_xfer_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 16, giving the bytes per block; legal range 2..32.
REQ-002 SHALL have port clk_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset_reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port hw_port_i, input, 8 bits, the data byte from the to_hw_port PIO.
REQ-005 SHALL have port hw_sig_i, input, 2 bits, the command code from the to_hw_sig PIO.
REQ-006 SHALL have port sw_port_o, output, 8 bits, the data byte to the to_sw_port PIO.
REQ-007 SHALL have port sw_sig_o, output, 2 bits, the status code to the to_sw_sig PIO.
REQ-008 SHALL have ports blk_o (output, NBYTES*8), blk_valid_o (output, 1) and blk_ready_i (input, 1), carrying the assembled block to the engine.
REQ-009 SHALL have ports res_i (input, NBYTES*8), res_valid_i (input, 1) and res_ready_o (output, 1), carrying the engine result.

Function
REQ-010 SHALL use these sig codes: 00 IDLE, 01 WRITE, 10 READ, 11 ABORT; the same values apply to sw_sig_o as acknowledgements.
REQ-011 SHALL register hw_port_i and hw_sig_i in one stage; all decisions use the registered values.
REQ-012 SHALL update sw_sig_o at the second rising edge after a hw_sig_i change.
REQ-013 SHALL implement the states RX_IDLE, RX_ACK, ENG_REQ, ENG_WAIT, TX_IDLE, TX_ACK and ABORT.
REQ-014 In RX_IDLE on sig=01, SHALL shift the byte into the low end of the block register, drive sw_sig_o=01 and go to RX_ACK.
REQ-015 In RX_ACK on sig=00, SHALL drive sw_sig_o=00; if byte_cnt==NBYTES-1, clear byte_cnt and go to ENG_REQ, else increment byte_cnt and go to RX_IDLE.
REQ-016 Byte order: the first byte received SHALL end in blk_o[NBYTES*8-1 -: 8] (MSB first).
REQ-017 In ENG_REQ, blk_valid_o=1 and blk_o SHALL stay stable until blk_ready_i=1; the transfer happens on that cycle and the state goes to ENG_WAIT.
REQ-018 In ENG_WAIT, res_ready_o=1; on res_valid_i=1, SHALL load res_i into the block register and go to TX_IDLE.
REQ-019 In TX_IDLE on sig=10, SHALL drive sw_port_o with the top byte, drive sw_sig_o=10 and go to TX_ACK.
REQ-020 In TX_ACK on sig=00, SHALL drive sw_sig_o=00 and shift the register left by one byte; after the last byte, clear byte_cnt and go to RX_IDLE, else go to TX_IDLE.
REQ-021 sw_port_o SHALL hold its value until the next READ byte is presented.
REQ-022 Sig=11 in any state SHALL have priority: go to ABORT, drive sw_sig_o=11, clear byte_cnt, deassert blk_valid_o and res_ready_o.
REQ-023 In ABORT on sig=00, SHALL drive sw_sig_o=00 and go to RX_IDLE.
REQ-024 A sig code not valid for the current state (for example 10 in RX_IDLE, or 01 in ENG_WAIT) SHALL be ignored with no state change.
REQ-025 A result arriving while not in ENG_WAIT SHALL be ignored; res_ready_o=0 outside ENG_WAIT.

Reset
REQ-026 Reset SHALL force RX_IDLE, byte_cnt=0, block register=0, sw_port_o=0, sw_sig_o=00, blk_valid_o=0, res_ready_o=0 and input registers=0.
REQ-027 Reset asserted mid-transfer SHALL take effect at the next edge, discard partial data and override ABORT.

Configuration
REQ-028 With PIO_XFER_STATUS_EN defined, SHALL add output blk_cnt_o (16 bits) counting engine handshakes completed in ENG_REQ; it wraps 0xFFFF to 0, is cleared by reset only and is unaffected by ABORT.
REQ-029 Without PIO_XFER_STATUS_EN, blk_cnt_o and its counter SHALL be absent.

Structure
REQ-030 Package pio_xfer_pkg SHALL hold the state enum and the SIG_IDLE, SIG_WR, SIG_RD and SIG_ABORT constants.
REQ-031 Sub-module pio_xfer_shreg SHALL implement the NBYTES-byte register with load, shift-in and shift-out-top operations, used for both RX and TX.

Verification
REQ-032 Write bytes 0x00..0x0F with the full handshake -> blk_o=128'h000102...0F, blk_valid_o=1; hold blk_ready_i=0 for 5 cycles -> blk_o stays stable.
REQ-033 Engine returns res_i=128'hFFEE...00; 16 READ handshakes -> sw_port_o sequence 0xFF, 0xEE, ... 0x00; the state ends in RX_IDLE.
REQ-034 Sig=11 after 7 bytes -> sw_sig_o=11; then sig=00 -> sw_sig_o=00; next 16 bytes assemble cleanly with no stale data.
REQ-035 Sig=10 in RX_IDLE, and sig=01 in ENG_WAIT -> no state change, sw_sig_o stays 00.
REQ-036 Assert reset during TX_ACK -> all outputs take their REQ-026 values on the next edge.
REQ-037 With PIO_XFER_STATUS_EN, preload blk_cnt_o to 0xFFFF via a forced counter and complete one block -> blk_cnt_o=0x0000.
